lock_query_ctrl: RTL
====================

Name: lock_query_ctrl

Overview:
Sequencer that drives one locked benchmark FSM through a query. A query is: hold a key, pulse the FSM reset, step a stream of input vectors, and compare each Mealy output word with an expected word. The block generates the FSM's reset and its negedge-active step clock, so every vector is applied, settled, sampled and committed on a fixed 4-cycle schedule. It sits between the oracle/test harness (vector stream source) and the locked FSM instance; results feed key-search and equivalence logic.

Parameters:
NX, 10, FSM data-input width (vec_x[0] = x1, vec_x[NX-1] = xNX)
NY, 11, FSM output width (dut_y[0] = y1)
NK, 1, key width
LW, 5, vector-count width; max query length 2^LW-1
STOP_ON_MM, 0, 1 = end the query at the first mismatch

Ports:
clk  in  1  system clock, posedge
rst  in  1  reset
start  in  1  query start pulse, honoured only in IDLE
key_in  in  NK  key for this query, latched at start
seq_len  in  LW  number of vectors, latched at start
vec_valid  in  1  vector stream valid
vec_ready  out  1  vector stream ready
vec_x  in  NX  FSM input vector
vec_y_exp  in  NY  expected FSM output for vec_x in the current state
dut_clk  out  1  FSM step clock; the FSM advances on its falling edge
dut_rst  out  1  FSM reset, active-high
dut_x  out  NX  registered FSM inputs
dut_key  out  NK  registered FSM key
dut_y  in  NY  FSM outputs (combinational, Mealy)
busy  out  1  query in progress
done  out  1  one-cycle pulse at query end
mismatch  out  1  sticky: at least one compare failed this query
mm_idx  out  LW  index of the first failing vector
mm_cnt  out  LW  failing-vector count, saturating at all-ones

Behaviour:
- rst is asynchronous, active-high. It forces all registers at once, including in mid-query:
  - state = IDLE
  - dut_rst = 1, dut_clk = 1, dut_x = 0, dut_key = 0
  - vec_ready = 0, busy = 0, done = 0
  - mismatch = 0, mm_idx = 0, mm_cnt = 0
  - vector counter = 0
- All other logic is posedge clk. All outputs are registered.
- IDLE:
  - dut_rst = 1, dut_clk = 1.
  - On start: latch key_in into dut_key and seq_len into the length register; clear mismatch, mm_idx, mm_cnt and the counter; set busy = 1.
  - If seq_len = 0: go to FIN. Otherwise go to DRST.
- DRST: hold dut_rst = 1 for exactly 2 cycles, then deassert dut_rst and go to APPLY.
- APPLY:
  - vec_ready = 1; dut_clk = 1.
  - On vec_valid & vec_ready: register vec_x into dut_x and vec_y_exp into the expected register; drop vec_ready; go to SETTLE.
  - With no valid, wait indefinitely. dut_x holds its previous value and the FSM does not step.
- SETTLE: one cycle for dut_y to settle; go to SAMPLE.
- SAMPLE:
  - Compare dut_y with the expected word.
  - On inequality: set mismatch; if mismatch was 0, load mm_idx = counter; increment mm_cnt unless it is all-ones.
  - Drive dut_clk = 0; this falling edge commits the FSM transition. Go to ADV.
- ADV:
  - dut_clk = 1. dut_x stays stable through the falling edge and until the next accepted vector.
  - If counter = seq_len-1, or (STOP_ON_MM and mismatch), go to FIN. Otherwise increment the counter and go to APPLY.
- FIN:
  - done = 1 for one cycle; busy = 0; dut_rst = 1 on the next cycle.
  - Results (mismatch, mm_idx, mm_cnt) hold until the next start.
  - Go to IDLE.
- Timing:
  - Throughput is 4 cycles per vector when vec_valid is held high.
  - Query latency is 3 + 4·seq_len cycles from start to done.
- Boundary conditions:
  - start while busy: ignored.
  - start and rst together: rst wins.
  - vec_valid outside APPLY: ignored; a vector is consumed only when vec_ready = 1.
  - seq_len = 2^LW-1: the counter does not wrap before FIN.

Test Plan:
- Matching two-vector query:
  - Setup: key = 1, seq_len = 2.
  - Vector 0: x1 = x2 = x3 = x4 = x9 = x10 = 1, exp 0x048 (y4, y7).
  - Vector 1: x6 = 1, exp 0x080 (y8).
  - Required: done pulse 11 cycles after start; mismatch = 0; mm_cnt = 0; dut_clk shows exactly 2 falling edges.
- Same query with vector 1 exp = 0x000: mismatch = 1, mm_idx = 1, mm_cnt = 1.
- seq_len = 0: done exactly 1 cycle after start; dut_rst never deasserts; vec_ready stays 0.
- Stall: hold vec_valid = 0 for 20 cycles in APPLY. Required: dut_clk stays 1, dut_x unchanged, no done; the query completes normally once valid rises.
- STOP_ON_MM = 1, seq_len = 5, vector 1 mismatches: done after the vector-1 ADV; only 2 vectors consumed; mm_idx = 1.
- rst asserted in SAMPLE of vector 2: all outputs are at their reset values immediately (async). A following start runs a clean query that ignores the aborted one.

Source files
------------

// File: rtl/lock_query_ctrl_if.sv
// Vector stream from the oracle/test harness into the lock query sequencer.
// A vector moves on a clock edge where vec_valid and vec_ready are both high; vec_x and
// vec_y_exp must be stable while vec_valid is high, and vec_ready never waits on vec_valid.
interface lock_query_ctrl_if #(
    parameter int NX = 10,
    parameter int NY = 11
);
    logic          vec_valid;
    logic          vec_ready;
    logic [NX-1:0] vec_x;
    logic [NY-1:0] vec_y_exp;

    modport master (output vec_valid, output vec_x, output vec_y_exp, input vec_ready);
    modport slave  (input vec_valid, input vec_x, input vec_y_exp, output vec_ready);
endinterface

// File: rtl/lock_query_ctrl.sv
// Drives one locked FSM through a query: hold key, pulse reset, step vectors on a 4-cycle
// schedule, compare each Mealy output word with its expected word and report mismatches.
module lock_query_ctrl #(
    parameter int NX         = 10,
    parameter int NY         = 11,
    parameter int NK         = 1,
    parameter int LW         = 5,
    parameter int STOP_ON_MM = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NK-1:0]     key_in,
    input  logic [LW-1:0]     seq_len,
    lock_query_ctrl_if.slave  vec,
    output logic              dut_clk,
    output logic              dut_rst,
    output logic [NX-1:0]     dut_x,
    output logic [NK-1:0]     dut_key,
    input  logic [NY-1:0]     dut_y,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [LW-1:0]     mm_idx,
    output logic [LW-1:0]     mm_cnt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRST   = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        ADV    = 3'd5,
        FIN    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          rst_cnt_q, rst_cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] vcnt_q, vcnt_d;
    logic [NY-1:0] exp_q, exp_d;
    logic          dut_clk_q, dut_clk_d;
    logic          dut_rst_q, dut_rst_d;
    logic [NX-1:0] dut_x_q, dut_x_d;
    logic [NK-1:0] dut_key_q, dut_key_d;
    logic          vec_ready_q, vec_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mismatch_q, mismatch_d;
    logic [LW-1:0] mm_idx_q, mm_idx_d;
    logic [LW-1:0] mm_cnt_q, mm_cnt_d;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        len_d       = len_q;
        vcnt_d      = vcnt_q;
        exp_d       = exp_q;
        dut_clk_d   = 1'b1;
        dut_rst_d   = dut_rst_q;
        dut_x_d     = dut_x_q;
        dut_key_d   = dut_key_q;
        vec_ready_d = vec_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mismatch_d  = mismatch_q;
        mm_idx_d    = mm_idx_q;
        mm_cnt_d    = mm_cnt_q;

        case (state_q)
            IDLE: begin
                dut_rst_d = 1'b1;
                if (start) begin
                    dut_key_d  = key_in;
                    len_d      = seq_len;
                    mismatch_d = 1'b0;
                    mm_idx_d   = '0;
                    mm_cnt_d   = '0;
                    vcnt_d     = '0;
                    rst_cnt_d  = 1'b0;
                    if (seq_len == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DRST;
                        busy_d  = 1'b1;
                    end
                end
            end
            DRST: begin
                if (rst_cnt_q) begin
                    state_d     = APPLY;
                    dut_rst_d   = 1'b0;
                    vec_ready_d = 1'b1;
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            APPLY: begin
                if (vec.vec_valid && vec_ready_q) begin
                    dut_x_d     = vec.vec_x;
                    exp_d       = vec.vec_y_exp;
                    vec_ready_d = 1'b0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: state_d = SAMPLE;
            SAMPLE: begin
                // dut_y is sampled on the same edge that drops dut_clk, so the
                // compare sees the pre-transition Mealy output.
                if (dut_y != exp_q) begin
                    mismatch_d = 1'b1;
                    if (!mismatch_q) mm_idx_d = vcnt_q;
                    if (mm_cnt_q != {LW{1'b1}}) mm_cnt_d = mm_cnt_q + 1'b1;
                end
                dut_clk_d = 1'b0;
                state_d   = ADV;
            end
            ADV: begin
                if ((vcnt_q == len_q - 1'b1) || ((STOP_ON_MM != 0) && mismatch_q)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    vcnt_d      = vcnt_q + 1'b1;
                    vec_ready_d = 1'b1;
                    state_d     = APPLY;
                end
            end
            FIN: begin
                dut_rst_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rst_cnt_q   <= 1'b0;
            len_q       <= '0;
            vcnt_q      <= '0;
            exp_q       <= '0;
            dut_clk_q   <= 1'b1;
            dut_rst_q   <= 1'b1;
            dut_x_q     <= '0;
            dut_key_q   <= '0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            mm_idx_q    <= '0;
            mm_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            len_q       <= len_d;
            vcnt_q      <= vcnt_d;
            exp_q       <= exp_d;
            dut_clk_q   <= dut_clk_d;
            dut_rst_q   <= dut_rst_d;
            dut_x_q     <= dut_x_d;
            dut_key_q   <= dut_key_d;
            vec_ready_q <= vec_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            mm_idx_q    <= mm_idx_d;
            mm_cnt_q    <= mm_cnt_d;
        end
    end

    assign vec.vec_ready = vec_ready_q;
    assign dut_clk       = dut_clk_q;
    assign dut_rst       = dut_rst_q;
    assign dut_x         = dut_x_q;
    assign dut_key       = dut_key_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mismatch      = mismatch_q;
    assign mm_idx        = mm_idx_q;
    assign mm_cnt        = mm_cnt_q;
    assign dbg_state     = state_q;

endmodule
